mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS memory-access stage: accepts EX/MEM pipeline signals, performs data-memory load/store, and registers results into the MEM/WB pipeline latch.
- Outputs feed the writeback mux directly: `mem_Read_data`, `mem_ALU_result`, `MemtoReg`, plus the `RegWrite` / destination register.
- Contains word-addressed data RAM, stall/flush handling and bubble insertion.

Parameters:
- ADDR_W, 8, data RAM word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX/MEM slot holds a real instruction
- ex_ALU_result  input  32  address for lw/sw, result otherwise
- ex_Write_data  input  32  store data (rt value)
- ex_MemRead  input  1  load
- ex_MemWrite  input  1  store
- ex_MemtoReg  input  1  writeback selects memory data
- ex_RegWrite  input  1  instruction writes register file
- ex_write_reg  input  5  destination register
- stall  input  1  hold MEM/WB latch, suppress store
- flush  input  1  replace incoming instruction with bubble
- mem_valid  output  1  MEM/WB slot valid
- mem_Read_data  output  32  loaded word
- mem_ALU_result  output  32  passed-through ALU result
- MemtoReg  output  1  to writeback mux
- mem_RegWrite  output  1  register-file write enable
- mem_write_reg  output  5  destination register
- mem_misalign  output  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0 (`mem_valid`, `mem_Read_data`, `mem_ALU_result`, `MemtoReg`, `mem_RegWrite`, `mem_write_reg`, `mem_misalign`). RAM contents are not reset. Reset asserted mid-store: the store is not performed if rst_n is low at the edge.
- Address: word index = `ex_ALU_result[ADDR_W+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Latency: 1 cycle. Inputs present in cycle N appear on the MEM/WB outputs after edge N+1.
- Load: RAM is read combinationally at the word index; the value is captured into `mem_Read_data` at the edge.
- Store: RAM is written at the edge when ex_valid & ex_MemWrite & !stall & !flush.
- Non-load cycles: `mem_Read_data` = 0 unless ex_MemRead & ex_valid.
- ex_MemRead and ex_MemWrite both high: treated as a store; `mem_Read_data` = 0.
- Back-to-back sw then lw, same address: the lw returns the newly stored word, because the write commits at the edge before the lw reads.
- Register-file write guard: `mem_RegWrite` = ex_RegWrite & ex_valid & (ex_write_reg != 0). A write to $0 never reaches the register file.
- Stall (stall=1, flush=0): all MEM/WB outputs hold, store suppressed, RAM unchanged.
- Flush (flush=1, any stall): at the edge, `mem_valid`, `mem_RegWrite`, `MemtoReg` and `mem_misalign` are cleared. Store suppressed. Data fields may take any value. Flush has priority over stall.
- Invalid input (ex_valid=0): behaves as a bubble, same as flush.
- Control FSM: implicit two-mode latch, LOAD (capture) / HOLD (stall), selected per cycle. No multi-cycle states.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a valid lw/sw with `ex_ALU_result[1:0] != 0`:
  - suppresses any store;
  - forces `mem_RegWrite` = 0;
  - sets `mem_misalign` = 1 for that slot (same latency as data).
- Undefined:
  - low two address bits are ignored and the access proceeds to the aligned word;
  - `mem_misalign` is tied to 0.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_RegWrite=1 -> all outputs 0 immediately, without waiting for clk.
- Store then load: sw 0xDEADBEEF to addr 0x10; next cycle lw addr 0x10, MemtoReg=1, write_reg=18 -> one cycle later `mem_Read_data`=0xDEADBEEF, `mem_RegWrite`=1, `mem_write_reg`=18, `MemtoReg`=1.
- ALU pass-through: ex_ALU_result=42, MemRead=0, write_reg=3 -> `mem_ALU_result`=42, `mem_Read_data`=0, `MemtoReg`=0.
- Stall/flush: sw 0x11111111 to addr 0x20 with stall=1 -> RAM[8] unchanged and outputs held. Repeat with stall=1, flush=1 -> `mem_valid`=0, no store.
- $0 and wrap: write_reg=0, RegWrite=1 -> `mem_RegWrite`=0. With ADDR_W=8, sw to 0x400 then lw from 0x0 -> same word returned.
- Misalignment with MEM_MISALIGN_TRAP_EN defined: sw to addr 0x13 -> `mem_misalign`=1 and RAM[4] unchanged. Without the macro -> RAM[4] written, `mem_misalign`=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bus for the MIPS memory stage: pipeline inputs, stall/flush controls and
// the registered writeback-side outputs. The pipeline drives through master; the stage is slave.
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              ex_valid;
    logic [DATA_W-1:0] ex_ALU_result;
    logic [DATA_W-1:0] ex_Write_data;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_MemtoReg;
    logic              ex_RegWrite;
    logic [4:0]        ex_write_reg;
    logic              stall;
    logic              flush;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_Read_data;
    logic [DATA_W-1:0] mem_ALU_result;
    logic              MemtoReg;
    logic              mem_RegWrite;
    logic [4:0]        mem_write_reg;
    logic              mem_misalign;

    modport master (
        output ex_valid, ex_ALU_result, ex_Write_data, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_RegWrite, ex_write_reg, stall, flush,
        input  mem_valid, mem_Read_data, mem_ALU_result, MemtoReg, mem_RegWrite,
               mem_write_reg, mem_misalign
    );

    modport slave (
        input  ex_valid, ex_ALU_result, ex_Write_data, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_RegWrite, ex_write_reg, stall, flush,
        output mem_valid, mem_Read_data, mem_ALU_result, MemtoReg, mem_RegWrite,
               mem_write_reg, mem_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word-addressed data RAM plus the MEM/WB pipeline latch.
// Define MEM_MISALIGN_TRAP_EN to trap lw/sw with a non-word-aligned address.
module mem_stage #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic      clk,
    input logic      rst_n,
    mem_stage_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ModeLoad,
        ModeHold
    } mode_e;

    logic [DATA_W-1:0] ram [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] ram_rdata;
    mode_e             mode;
    logic              live;
    logic              access;
    logic              misaligned;
    logic              trap;
    logic              do_store;
    logic              do_load;
    logic              reg_write_ok;

    logic              valid_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] alu_result_q;
    logic              mem_to_reg_q;
    logic              reg_write_q;
    logic [4:0]        write_reg_q;
    logic              misalign_q;

    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign word_idx  = bus.ex_ALU_result[ADDR_W+1:2];
    assign ram_rdata = ram[word_idx];

    assign live   = bus.ex_valid && !bus.flush;
    assign access = bus.ex_MemRead || bus.ex_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = access && (bus.ex_ALU_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign trap = live && misaligned;

    // A stall without flush holds the latch; flush always wins and loads a bubble.
    assign mode = (bus.stall && !bus.flush) ? ModeHold : ModeLoad;

    assign do_store = rst_n && bus.ex_valid && bus.ex_MemWrite && !bus.stall && !bus.flush
                      && !trap;

    // Simultaneous MemRead/MemWrite is treated as a store, so it returns no load data.
    assign do_load = bus.ex_valid && bus.ex_MemRead && !bus.ex_MemWrite;

    assign reg_write_ok = live && bus.ex_RegWrite && (bus.ex_write_reg != 5'd0) && !trap;

    always_ff @(posedge clk) begin
        if (do_store) begin
            ram[word_idx] <= bus.ex_Write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            misalign_q   <= 1'b0;
        end else if (mode == ModeLoad) begin
            valid_q      <= live;
            read_data_q  <= do_load ? ram_rdata : '0;
            alu_result_q <= bus.ex_ALU_result;
            mem_to_reg_q <= live && bus.ex_MemtoReg;
            reg_write_q  <= reg_write_ok;
            write_reg_q  <= bus.ex_write_reg;
            misalign_q   <= trap;
        end
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_Read_data  = read_data_q;
    assign bus.mem_ALU_result = alu_result_q;
    assign bus.MemtoReg       = mem_to_reg_q;
    assign bus.mem_RegWrite   = reg_write_q;
    assign bus.mem_write_reg  = write_reg_q;
    assign bus.mem_misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, store/load, pass-through, stall/flush, $0 guard,
// address wrap and misaligned accesses (expectations follow MEM_MISALIGN_TRAP_EN).
module tb_mem_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    mem_stage_if #(.DATA_W(32)) bus ();

    mem_stage #(
        .ADDR_W(8),
        .DATA_W(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [4:0] wreg, input logic st, input logic fl);
        bus.ex_valid      = v;
        bus.ex_ALU_result = alu;
        bus.ex_Write_data = wdata;
        bus.ex_MemRead    = rd;
        bus.ex_MemWrite   = wr;
        bus.ex_MemtoReg   = m2r;
        bus.ex_RegWrite   = rw;
        bus.ex_write_reg  = wreg;
        bus.stall         = st;
        bus.flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control vector order: {valid, RegWrite, MemtoReg, misalign, write_reg}
    task automatic test_reset();
        logic [8:0] ctl;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #12;
        ctl = {bus.mem_valid, bus.mem_RegWrite, bus.MemtoReg, bus.mem_misalign,
               bus.mem_write_reg};
        checks++;
        if ({ctl, bus.mem_Read_data, bus.mem_ALU_result} !== 73'd0)
            $display("FAIL reset_initial got ctl=%h rd=%h alu=%h want all 0", ctl,
                     bus.mem_Read_data, bus.mem_ALU_result);
        else passed++;
        rst_n = 1'b1;
        tick();

        drive(1'b1, 32'h30, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_Read_data !== 32'hAAAA5555)
            $display("FAIL pre_reset_load got v=%b rd=%h want v=1 rd=aaaa5555",
                     bus.mem_valid, bus.mem_Read_data);
        else passed++;

        // Asynchronous reset mid-cycle while a RegWrite instruction is presented.
        #2 rst_n = 1'b0;
        #1;
        ctl = {bus.mem_valid, bus.mem_RegWrite, bus.MemtoReg, bus.mem_misalign,
               bus.mem_write_reg};
        checks++;
        if ({ctl, bus.mem_Read_data, bus.mem_ALU_result} !== 73'd0)
            $display("FAIL reset_async got ctl=%h rd=%h alu=%h want all 0", ctl,
                     bus.mem_Read_data, bus.mem_ALU_result);
        else passed++;

        // Store presented across an edge with reset asserted must not land.
        drive(1'b1, 32'h30, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'hAAAA5555)
            $display("FAIL reset_store_blocked got %h want aaaa5555", bus.mem_Read_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_RegWrite !== 1'b0 || bus.mem_Read_data !== 32'h0)
            $display("FAIL sw_slot got v=%b rw=%b rd=%h want v=1 rw=0 rd=0", bus.mem_valid,
                     bus.mem_RegWrite, bus.mem_Read_data);
        else passed++;
        drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd18, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'hDEADBEEF || bus.mem_RegWrite !== 1'b1 ||
            bus.mem_write_reg !== 5'd18 || bus.MemtoReg !== 1'b1)
            $display("FAIL sw_lw got rd=%h rw=%b wr=%0d m2r=%b want deadbeef 1 18 1",
                     bus.mem_Read_data, bus.mem_RegWrite, bus.mem_write_reg, bus.MemtoReg);
        else passed++;
    endtask

    task automatic test_passthrough();
        drive(1'b1, 32'd42, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_ALU_result !== 32'd42 || bus.mem_Read_data !== 32'h0 ||
            bus.MemtoReg !== 1'b0 || bus.mem_RegWrite !== 1'b1 || bus.mem_write_reg !== 5'd3)
            $display("FAIL alu_pass got alu=%0d rd=%h m2r=%b rw=%b wr=%0d want 42 0 0 1 3",
                     bus.mem_ALU_result, bus.mem_Read_data, bus.MemtoReg, bus.mem_RegWrite,
                     bus.mem_write_reg);
        else passed++;
        // Read and write together behave as a store.
        drive(1'b1, 32'h50, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'h0)
            $display("FAIL rd_wr_both got %h want 0", bus.mem_Read_data);
        else passed++;
        drive(1'b1, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'hCAFEF00D)
            $display("FAIL rd_wr_stored got %h want cafef00d", bus.mem_Read_data);
        else passed++;
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h20, 32'h0BADC0DE, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd18, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_Read_data !== 32'hDEADBEEF ||
            bus.mem_RegWrite !== 1'b1 || bus.mem_write_reg !== 5'd18 ||
            bus.MemtoReg !== 1'b1 || bus.mem_ALU_result !== 32'h10)
            $display("FAIL stall_hold got v=%b rd=%h rw=%b wr=%0d m2r=%b alu=%h want 1 deadbeef 1 18 1 10",
                     bus.mem_valid, bus.mem_Read_data, bus.mem_RegWrite, bus.mem_write_reg,
                     bus.MemtoReg, bus.mem_ALU_result);
        else passed++;
        drive(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1);
        tick();
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.mem_RegWrite !== 1'b0 || bus.MemtoReg !== 1'b0 ||
            bus.mem_misalign !== 1'b0)
            $display("FAIL flush_bubble got v=%b rw=%b m2r=%b mis=%b want 0 0 0 0",
                     bus.mem_valid, bus.mem_RegWrite, bus.MemtoReg, bus.mem_misalign);
        else passed++;
        drive(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'h0BADC0DE)
            $display("FAIL stall_no_store got %h want 0badc0de", bus.mem_Read_data);
        else passed++;
        drive(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.mem_RegWrite !== 1'b0 || bus.MemtoReg !== 1'b0 ||
            bus.mem_Read_data !== 32'h0)
            $display("FAIL invalid_bubble got v=%b rw=%b m2r=%b rd=%h want 0 0 0 0",
                     bus.mem_valid, bus.mem_RegWrite, bus.MemtoReg, bus.mem_Read_data);
        else passed++;
    endtask

    task automatic test_zero_wrap();
        drive(1'b1, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_RegWrite !== 1'b0 || bus.mem_valid !== 1'b1)
            $display("FAIL reg_zero got rw=%b v=%b want rw=0 v=1", bus.mem_RegWrite,
                     bus.mem_valid);
        else passed++;
        drive(1'b1, 32'h400, 32'h5A5A1234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'h5A5A1234)
            $display("FAIL wrap_low got %h want 5a5a1234", bus.mem_Read_data);
        else passed++;
        drive(1'b1, 32'h3FC, 32'h00000077, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h7FC, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== 32'h00000077)
            $display("FAIL wrap_top got %h want 00000077", bus.mem_Read_data);
        else passed++;
    endtask

    task automatic test_misalign();
        logic        exp_mis;
        logic        exp_rw;
        logic [31:0] exp_word;
`ifdef MEM_MISALIGN_TRAP_EN
        exp_mis  = 1'b1;
        exp_rw   = 1'b0;
        exp_word = 32'h44444444;
`else
        exp_mis  = 1'b0;
        exp_rw   = 1'b1;
        exp_word = 32'h99999999;
`endif
        drive(1'b1, 32'h10, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h13, 32'h99999999, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_misalign !== exp_mis)
            $display("FAIL misalign_sw got %b want %b", bus.mem_misalign, exp_mis);
        else passed++;
        drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_Read_data !== exp_word || bus.mem_misalign !== 1'b0)
            $display("FAIL misalign_ram got rd=%h mis=%b want rd=%h mis=0", bus.mem_Read_data,
                     bus.mem_misalign, exp_word);
        else passed++;
        drive(1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.mem_misalign !== exp_mis || bus.mem_RegWrite !== exp_rw ||
            bus.mem_Read_data !== exp_word)
            $display("FAIL misalign_lw got mis=%b rw=%b rd=%h want mis=%b rw=%b rd=%h",
                     bus.mem_misalign, bus.mem_RegWrite, bus.mem_Read_data, exp_mis, exp_rw,
                     exp_word);
        else passed++;
        drive(1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        tick();
        checks++;
        if (bus.mem_misalign !== 1'b0 || bus.mem_valid !== 1'b0)
            $display("FAIL misalign_flush got mis=%b v=%b want 0 0", bus.mem_misalign,
                     bus.mem_valid);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_back_to_back();
        test_passthrough();
        test_stall_flush();
        test_zero_wrap();
        test_misalign();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
